// File: rtl/uart_tx_arb.sv
// uart_tx_arb: two-requester arbiter feeding one shared uart_tx, with a start watchdog
module uart_tx_arb #(
  parameter int FIXED_PRIO = 0,
  parameter int WD_CYCLES  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic       req1_valid,
  input  logic [7:0] req0_data,
  input  logic [7:0] req1_data,
  output logic       req0_ack,
  output logic       req1_ack,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_ready,
  output logic       busy,
  output logic       grant,
  output logic       err
);
  localparam int WW = $clog2(WD_CYCLES + 1) > 3 ? $clog2(WD_CYCLES + 1) : 3;
  typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;
  state_t state, state_n;
  logic [WW-1:0] wd, wd_n;
  logic win, go, expire;
  // Winner selection, transfer qualification and next-state logic
  always_comb begin
    state_n = state;
    wd_n    = wd;
    win     = FIXED_PRIO != 0 ? ~req0_valid : (req0_valid & req1_valid) ? ~grant : req1_valid;
    go      = state == IDLE && (req0_valid | req1_valid) && tx_ready;
    expire  = state == WAIT_BUSY && tx_ready && wd >= WW'(WD_CYCLES - 1);
    unique case (state)
      IDLE:      state_n = go ? START : IDLE;
      START: begin
        state_n = WAIT_BUSY;
        wd_n    = '0;
      end
      WAIT_BUSY: begin
        state_n = !tx_ready ? WAIT_DONE : expire ? IDLE : WAIT_BUSY;
        wd_n    = tx_ready && wd != WW'(WD_CYCLES) ? wd + 1'b1 : wd;
      end
      WAIT_DONE: state_n = tx_ready ? IDLE : WAIT_DONE;
      default:   state_n = IDLE;
    endcase
  end
  // State register plus registered outputs; grant and tx_data only move on an accepted byte
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wd       <= '0;
      tx_start <= 1'b0;
      req0_ack <= 1'b0;
      req1_ack <= 1'b0;
      busy     <= 1'b0;
      err      <= 1'b0;
      tx_data  <= 8'h00;
      grant    <= 1'b1;
    end else begin
      state    <= state_n;
      wd       <= wd_n;
      tx_start <= go;
      req0_ack <= go & ~win;
      req1_ack <= go & win;
      busy     <= state_n != IDLE;
      err      <= err | expire;
      if (go) begin
        tx_data <= win ? req1_data : req0_data;
        grant   <= win;
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: random and directed checks of a round-robin and a fixed-priority arbiter against a transfer-level model
module tb_uart_tx_arb;
  logic clk = 1'b0;
  logic rst;
  logic v0[2], v1[2], rdy[2], st[2], a0[2], a1[2], bsy[2], gr[2], er[2];
  logic [7:0] d0[2], d1[2], txd[2];
  int rc0[2], rc1[2], lowcnt[2], umode[2], starts[2], snap[2];
  logic [7:0] seq0[$], seq1[$];
  logic [7:0] exp_rr[4], exp_fp[4];
  bit fixed, rlen;
  int ulen;
  int tests = 0, fails = 0;
  logic m_st[2], m_a0[2], m_a1[2], m_bsy[2], m_gr[2], m_er[2], m_fresh[2], m_low[2];
  logic [7:0] m_d[2];
  int m_hi[2];

  always #5 clk = ~clk;

  uart_tx_arb #(.FIXED_PRIO(0), .WD_CYCLES(4)) u_rr (
    .clk(clk), .rst(rst), .req0_valid(v0[0]), .req1_valid(v1[0]), .req0_data(d0[0]), .req1_data(d1[0]),
    .req0_ack(a0[0]), .req1_ack(a1[0]), .tx_start(st[0]), .tx_data(txd[0]), .tx_ready(rdy[0]),
    .busy(bsy[0]), .grant(gr[0]), .err(er[0]));

  uart_tx_arb #(.FIXED_PRIO(1), .WD_CYCLES(5)) u_fp (
    .clk(clk), .rst(rst), .req0_valid(v0[1]), .req1_valid(v1[1]), .req0_data(d0[1]), .req1_data(d1[1]),
    .req0_ack(a0[1]), .req1_ack(a1[1]), .tx_start(st[1]), .tx_data(txd[1]), .tx_ready(rdy[1]),
    .busy(bsy[1]), .grant(gr[1]), .err(er[1]));

  function automatic int wd_lim(int i);
    return i == 0 ? 4 : 5;
  endfunction

  // instance 1 is fixed priority; instance 0 alternates away from the last winner on a contest
  function automatic logic pick(int i);
    if (i == 1) return !v0[i];
    if (v0[i] && v1[i]) return !m_gr[i];
    return v1[i];
  endfunction

  // Transfer-level model: a transfer is accepted when idle with a request and a ready uart,
  // then lasts until the uart has been seen busy and idle again, or until the watchdog expires.
  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_st[i] <= 1'b0; m_a0[i] <= 1'b0; m_a1[i] <= 1'b0; m_bsy[i] <= 1'b0;
        m_gr[i] <= 1'b1; m_er[i] <= 1'b0; m_d[i] <= 8'h00;
        m_fresh[i] <= 1'b0; m_low[i] <= 1'b0; m_hi[i] <= 0;
      end else begin
        m_st[i] <= 1'b0; m_a0[i] <= 1'b0; m_a1[i] <= 1'b0;
        if (!m_bsy[i]) begin
          if ((v0[i] || v1[i]) && rdy[i]) begin
            m_st[i] <= 1'b1;
            m_a0[i] <= !pick(i);
            m_a1[i] <= pick(i);
            m_gr[i] <= pick(i);
            m_d[i] <= pick(i) ? d1[i] : d0[i];
            m_bsy[i] <= 1'b1; m_fresh[i] <= 1'b1; m_low[i] <= 1'b0; m_hi[i] <= 0;
          end
        end else if (m_fresh[i]) begin
          m_fresh[i] <= 1'b0;
        end else if (!m_low[i]) begin
          if (!rdy[i]) m_low[i] <= 1'b1;
          else begin
            m_hi[i] <= m_hi[i] + 1;
            if (m_hi[i] + 1 == wd_lim(i)) begin
              m_er[i] <= 1'b1;
              m_bsy[i] <= 1'b0;
            end
          end
        end else if (rdy[i]) begin
          m_bsy[i] <= 1'b0;
        end
      end
    end
  end

  task automatic chk(string n, int i, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d]: got %0h expected %0h", n, i, act, exp);
    end
  endtask

  // requesters advance on their ack; the uart model goes busy for a while after each start
  task automatic drive();
    for (int i = 0; i < 2; i++) begin
      if (st[i]) begin
        if (i == 0) seq0.push_back(txd[i]);
        else seq1.push_back(txd[i]);
        starts[i]++;
      end
      if (a0[i]) begin
        rc0[i]--;
        if (!fixed) d0[i] = 8'($urandom);
      end
      if (a1[i]) begin
        rc1[i]--;
        if (!fixed) d1[i] = 8'($urandom);
      end
      v0[i] = rc0[i] > 0;
      v1[i] = rc1[i] > 0;
      if (umode[i] == 2) rdy[i] = 1'b0;
      else if (umode[i] == 1) rdy[i] = 1'b1;
      else if (st[i]) begin
        rdy[i] = 1'b0;
        lowcnt[i] = (rlen ? 1 + int'($urandom % 10) : ulen) - 1;
      end else if (lowcnt[i] > 0) begin
        rdy[i] = 1'b0;
        lowcnt[i]--;
      end else rdy[i] = 1'b1;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("outputs", i, 32'({st[i], a0[i], a1[i], bsy[i], gr[i], er[i], txd[i]}),
          32'({m_st[i], m_a0[i], m_a1[i], m_bsy[i], m_gr[i], m_er[i], m_d[i]}));
      chk("one_ack", i, 32'(a0[i] & a1[i]), 32'd0);
      chk("start_eq_ack", i, 32'(st[i]), 32'(a0[i] | a1[i]));
    end
    drive();
  endtask

  task automatic chk_reset_vals(string n);
    for (int i = 0; i < 2; i++)
      chk(n, i, 32'({st[i], a0[i], a1[i], bsy[i], gr[i], er[i], txd[i]}), 32'({6'b000010, 8'h00}));
  endtask

  initial begin
    exp_rr[0] = 8'hA0; exp_rr[1] = 8'hB1; exp_rr[2] = 8'hA0; exp_rr[3] = 8'hB1;
    exp_fp[0] = 8'hA0; exp_fp[1] = 8'hA0; exp_fp[2] = 8'hA0; exp_fp[3] = 8'hB1;
    rst = 1'b1; fixed = 1'b0; rlen = 1'b1; ulen = 10;
    for (int i = 0; i < 2; i++) begin
      v0[i] = 1'b0; v1[i] = 1'b0; d0[i] = 8'h00; d1[i] = 8'h00; rdy[i] = 1'b1;
      rc0[i] = 0; rc1[i] = 0; lowcnt[i] = 0; umode[i] = 0; starts[i] = 0;
    end
    repeat (2) @(negedge clk);
    chk_reset_vals("reset_state");
    // single request for 8'h41
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rc0[i] = 1; d0[i] = 8'h41; v0[i] = 1'b1;
    end
    tick();
    for (int i = 0; i < 2; i++)
      chk("single_req", i, 32'({st[i], a0[i], a1[i], gr[i], txd[i]}), 32'({4'b1100, 8'h41}));
    repeat (20) tick();
    // one transfer from requester 1, then an asynchronous reset while waiting for the uart
    rlen = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rc1[i] = 1; d1[i] = 8'h5C; v1[i] = 1'b1;
    end
    repeat (4) tick();
    for (int i = 0; i < 2; i++) chk("busy_before_rst", i, 32'(bsy[i]), 32'd1);
    #2 rst = 1'b1;
    #1 chk_reset_vals("async_reset");
    fixed = 1'b1;
    seq0.delete();
    seq1.delete();
    for (int i = 0; i < 2; i++) begin
      lowcnt[i] = 0; rdy[i] = 1'b1; d0[i] = 8'hA0; d1[i] = 8'hB1;
    end
    rc0[0] = 2; rc1[0] = 2; rc0[1] = 3; rc1[1] = 1;
    for (int i = 0; i < 2; i++) begin
      v0[i] = 1'b1; v1[i] = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (100) tick();
    chk("rr_count", 0, 32'(seq0.size()), 32'd4);
    chk("fp_count", 1, 32'(seq1.size()), 32'd4);
    if (seq0.size() == 4) for (int k = 0; k < 4; k++) chk("rr_seq", k, 32'(seq0[k]), 32'(exp_rr[k]));
    if (seq1.size() == 4) for (int k = 0; k < 4; k++) chk("fp_seq", k, 32'(seq1[k]), 32'(exp_fp[k]));
    fixed = 1'b0;
    rlen = 1'b1;
    // uart held busy: requester 1 must wait, then be granted one cycle after ready rises
    for (int i = 0; i < 2; i++) begin
      umode[i] = 2; rdy[i] = 1'b0; rc1[i] = 1; d1[i] = 8'($urandom); v1[i] = 1'b1; snap[i] = starts[i];
    end
    repeat (20) tick();
    for (int i = 0; i < 2; i++) chk("blocked_starts", i, 32'(starts[i] - snap[i]), 32'd0);
    for (int i = 0; i < 2; i++) begin
      umode[i] = 0; rdy[i] = 1'b1;
    end
    tick();
    for (int i = 0; i < 2; i++) chk("unblock_grant", i, 32'({st[i], a1[i], gr[i]}), 32'({3'b111}));
    repeat (20) tick();
    // uart never goes busy: watchdog fires, then a normal transfer still completes
    for (int i = 0; i < 2; i++) begin
      umode[i] = 1; rc0[i] = 1; d0[i] = 8'($urandom); v0[i] = 1'b1;
    end
    repeat (15) tick();
    for (int i = 0; i < 2; i++) chk("watchdog", i, 32'({er[i], bsy[i]}), 32'({2'b10}));
    for (int i = 0; i < 2; i++) begin
      umode[i] = 0; rc1[i] = 1; d1[i] = 8'($urandom); v1[i] = 1'b1; snap[i] = starts[i];
    end
    repeat (20) tick();
    for (int i = 0; i < 2; i++) chk("after_watchdog", i, 32'({er[i], 8'(starts[i] - snap[i])}), 32'({1'b1, 8'd1}));
    // random traffic, uart behaviour and occasional resets
    repeat (600) begin
      for (int i = 0; i < 2; i++) begin
        if (rc0[i] == 0 && $urandom % 4 == 0) begin
          rc0[i] = 1 + int'($urandom % 3); d0[i] = 8'($urandom);
        end
        if (rc1[i] == 0 && $urandom % 4 == 0) begin
          rc1[i] = 1 + int'($urandom % 3); d1[i] = 8'($urandom);
        end
        v0[i] = rc0[i] > 0;
        v1[i] = rc1[i] > 0;
        if ($urandom % 40 == 0) umode[i] = ($urandom % 6 < 4) ? 0 : ($urandom % 2 == 0) ? 1 : 2;
      end
      tick();
      if ($urandom % 150 == 0) begin
        #2 rst = 1'b1;
        #1 chk_reset_vals("rand_reset");
        #3 rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
          lowcnt[i] = 0; rdy[i] = umode[i] != 2;
        end
      end
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
- REQ-001 SHALL have parameter FIXED_PRIO, default 0; 0 = round-robin arbitration, 1 = requester 0 always wins a contest.
- REQ-002 SHALL have parameter WD_CYCLES, default 4; the watchdog limit, in cycles, for tx_ready to fall after tx_start.
- REQ-003 SHALL have port clk, input, 1 bit; the single system clock, with all state updated on its rising edge.
- REQ-004 SHALL have port rst, input, 1 bit; asynchronous, active-high reset.
- REQ-005 SHALL have ports req0_valid and req1_valid, input, 1 bit each; high while the requester has a byte pending.
- REQ-006 SHALL have ports req0_data and req1_data, input, 8 bits each; the byte offered by each requester.
- REQ-007 SHALL have ports req0_ack and req1_ack, output, 1 bit each; a 1-cycle pulse when that requester's byte is accepted.
- REQ-008 SHALL have port tx_start, output, 1 bit; a 1-cycle start pulse to the shared uart_tx.
- REQ-009 SHALL have port tx_data, output, 8 bits; the byte to transmit, held stable from tx_start until the next grant.
- REQ-010 SHALL have port tx_ready, input, 1 bit; uart_tx idle flag, where 1 = idle.
- REQ-011 SHALL have port busy, output, 1 bit; high whenever the FSM is not in IDLE.
- REQ-012 SHALL have port grant, output, 1 bit; the index of the requester most recently accepted.
- REQ-013 SHALL have port err, output, 1 bit; sticky watchdog error flag.

Function
- REQ-014 FSM SHALL have four states: IDLE, START, WAIT_BUSY, WAIT_DONE; all outputs SHALL be registered.
- REQ-015 IDLE SHALL move to START when (req0_valid | req1_valid) & tx_ready.
  - On that edge: latch the winner's data into tx_data, set grant to the winner, and register the winner's ack.
- REQ-016 IDLE SHALL stay in IDLE when tx_ready = 0, even if a request is pending; no ack is issued.
- REQ-017 In START, tx_start = 1 and reqN_ack = 1 for the granted N, for exactly one cycle.
  - Latency: 1 cycle from the qualifying IDLE cycle.
  - START SHALL move to WAIT_BUSY unconditionally.
- REQ-018 WAIT_BUSY SHALL move to WAIT_DONE when tx_ready = 0.
  - If tx_ready stays 1 for WD_CYCLES consecutive cycles in WAIT_BUSY: set err = 1 and return to IDLE.
- REQ-019 WAIT_DONE SHALL move to IDLE when tx_ready = 1.
  - The next grant is therefore issued no sooner than the cycle after tx_ready rises.
- REQ-020 Arbitration with FIXED_PRIO = 0, single request: the requester that is valid wins.
- REQ-021 Arbitration with FIXED_PRIO = 0, both requests valid: the winner is the requester not equal to grant.
  - Because grant resets to 1, requester 0 wins the first contest after reset.
- REQ-022 Arbitration with FIXED_PRIO = 1: requester 0 wins whenever req0_valid = 1.
- REQ-023 Requester rules (a contract on the requesters, not checked by this block):
  - Hold reqN_valid and reqN_data stable until reqN_ack.
  - In the cycle of reqN_ack, either deassert reqN_valid or present the next byte.
  - A byte is accepted at most once.
- REQ-024 Simultaneous events: reqN_valid rising in the same cycle the FSM leaves WAIT_DONE SHALL be considered in the following IDLE cycle; it SHALL NOT be lost.
- REQ-025 Within one IDLE cycle, at most one ack SHALL be issued; the losing requester SHALL keep waiting with no ack.
- REQ-026 The watchdog counter SHALL be at least 3 bits wide, saturate at WD_CYCLES, and clear on entry to WAIT_BUSY.
- REQ-027 err SHALL be set only by a watchdog expiry and cleared only by rst; operation SHALL continue normally while err = 1.
- REQ-028 req0_ack and req1_ack SHALL never both be 1 in the same cycle; tx_start SHALL equal (req0_ack | req1_ack) in every cycle.

Reset
- REQ-029 rst = 1 SHALL immediately force, without waiting for clk:
  - state = IDLE;
  - tx_start, req0_ack, req1_ack, busy, err = 0;
  - tx_data = 8'h00;
  - grant = 1;
  - watchdog counter = 0.
- REQ-030 rst asserted mid-transfer (any non-IDLE state) SHALL abandon the transfer with no ack pending.
  - After release, the FSM restarts from IDLE, and the requester must still hold its byte.
- REQ-031 The first grant after rst deassertion SHALL occur no earlier than the first rising edge of clk with rst = 0.

Verification
- REQ-032 Single request: req0_valid = 1, req0_data = 8'h41, tx_ready = 1 -> next cycle tx_start = 1, req0_ack = 1, tx_data = 8'h41, grant = 0.
- REQ-033 Contest, round-robin: both valid continuously, data 8'hA0 / 8'hB1, with a uart_tx model (ready low 10 cycles after start) -> tx_data sequence A0, B1, A0, B1; acks alternate; never two starts without ready rising between them.
- REQ-034 Contest, FIXED_PRIO = 1: both valid, req0 held valid for 3 bytes -> 3 consecutive req0 grants; req1 granted only after req0_valid drops.
- REQ-035 Blocked transmitter: req1_valid = 1 with tx_ready = 0 for 20 cycles -> no ack and tx_start = 0 throughout; grant follows 1 cycle after tx_ready rises.
- REQ-036 Watchdog: tx_ready held at 1 after tx_start -> err = 1 after WD_CYCLES cycles, FSM returns to IDLE, and the next request is served normally.
- REQ-037 Reset mid-operation: rst pulsed while in WAIT_DONE -> outputs take their REQ-029 values asynchronously; after release, req0 wins a contest first.
